// File: rtl/ps2_step_decoder.sv
// ps2_step_decoder: receive-only PS/2 keyboard frame decoder.
// Turns make/break scancodes (including E0-extended codes) into level-held
// stepleft/stepright/stepjump requests for the character movement logic.
module ps2_step_decoder #(
    parameter int         SYNC_STAGES = 2,
    parameter int         TIMEOUT_CYC = 6500,
    parameter logic [7:0] KEY_LEFT    = 8'h6B,
    parameter logic [7:0] KEY_RIGHT   = 8'h74,
    parameter logic [7:0] KEY_JUMP    = 8'h29
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic stepleft,
    output logic stepright,
    output logic stepjump,
    output logic frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   data_bit;

    state_t                 state;
    logic [7:0]             shreg;
    logic                   par_bit;
    logic [2:0]             bit_cnt;
    logic [TW-1:0]          tcnt;
    logic                   ext;
    logic                   brk;
    logic                   frame_ok;

    // Synchronise both PS/2 lines; reset to the idle-high level so that
    // leaving reset never looks like a clock fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_bit = dat_sync[SYNC_STAGES-1];

    // A frame is good when the stop bit is high and the 8 data bits plus
    // parity contain an odd number of ones.
    assign frame_ok = data_bit & (^{shreg, par_bit});

    // Frame FSM, timeout and scancode layer in one register block, so key
    // states land one clock after the stop-bit fall cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            par_bit   <= 1'b0;
            bit_cnt   <= '0;
            tcnt      <= '0;
            ext       <= 1'b0;
            brk       <= 1'b0;
            stepleft  <= 1'b0;
            stepright <= 1'b0;
            stepjump  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (state != IDLE && !fall && tcnt == TW'(TIMEOUT_CYC - 1)) begin
                // Keyboard stopped clocking mid-frame: abort, drop prefixes.
                frame_err <= 1'b1;
                state     <= IDLE;
                tcnt      <= '0;
                ext       <= 1'b0;
                brk       <= 1'b0;
            end else if (fall) begin
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_bit) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg   <= {data_bit, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_bit;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (!frame_ok) begin
                            frame_err <= 1'b1;
                            ext       <= 1'b0;
                            brk       <= 1'b0;
                        end else if (shreg == 8'hE0) begin
                            ext <= 1'b1;
                        end else if (shreg == 8'hF0) begin
                            brk <= 1'b1;
                        end else begin
                            // Repeated makes just rewrite the same level.
                            if (ext && shreg == KEY_LEFT)
                                stepleft <= !brk;
                            if (ext && shreg == KEY_RIGHT)
                                stepright <= !brk;
                            if (!ext && shreg == KEY_JUMP)
                                stepjump <= !brk;
                            ext <= 1'b0;
                            brk <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_step_decoder.sv
// tb_ps2_step_decoder: scoreboard bench driving PS/2 frames into the decoder.
// Each frame pushes the expected {left,right,jump,err} after its stop bit;
// the entry is popped and compared three clocks after the stop-bit fall.
module tb_ps2_step_decoder;

    localparam int HALF = 60;   // half PS/2 clock period in clk cycles
    localparam int TO   = 200;  // TIMEOUT_CYC used for the bench

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;
    logic stepleft, stepright, stepjump, frame_err;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0] keys;   // {left, right, jump}
        logic       err;
    } exp_t;

    exp_t sb[$];

    ps2_step_decoder #(
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(TO),
        .KEY_LEFT   (8'h6B),
        .KEY_RIGHT  (8'h74),
        .KEY_JUMP   (8'h29)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .stepleft (stepleft),
        .stepright(stepright),
        .stepjump (stepjump),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One PS/2 bit: data set while clock high, then a falling edge.
    // On the stop bit the scoreboard entry is popped and checked.
    task automatic send_bit(input logic b, input bit is_stop);
        exp_t e;
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        if (is_stop) begin
            tick(3);
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty got=%b", {stepleft, stepright, stepjump, frame_err});
            end else begin
                e = sb.pop_front();
                if ({stepleft, stepright, stepjump, frame_err} !== e) begin
                    failures++;
                    $display("FAIL stop_result got={l,r,j,err}=%b exp=%b",
                             {stepleft, stepright, stepjump, frame_err}, e);
                end
            end
            tick(1);
            checks++;
            if (frame_err !== 1'b0) begin
                failures++;
                $display("FAIL err_pulse_width got=%b exp=0", frame_err);
            end
            tick(HALF - 4);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par,
                              input logic [2:0] keys, input logic err);
        sb.push_back('{keys: keys, err: err});
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            send_bit(code[i], 1'b0);
        send_bit((~^code) ^ bad_par, 1'b0);
        send_bit(1'b1, 1'b1);
        tick(20);
    endtask

    // Start bit plus the first nbits data bits, then the clock stays high.
    task automatic send_partial(input logic [7:0] code, input int nbits);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nbits; i++)
            send_bit(code[i], 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        tick(5);
        checks++;
        if ({stepleft, stepright, stepjump, frame_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_in got=%b exp=0000", {stepleft, stepright, stepjump, frame_err});
        end
        rst = 1'b0;
        tick(5);
        checks++;
        if ({stepleft, stepright, stepjump, frame_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_out got=%b exp=0000", {stepleft, stepright, stepjump, frame_err});
        end
    endtask

    task automatic test_right_make_break;
        send_frame(8'hE0, 0, 3'b000, 0);
        send_frame(8'h74, 0, 3'b010, 0);
        send_frame(8'hE0, 0, 3'b010, 0);
        send_frame(8'hF0, 0, 3'b010, 0);
        send_frame(8'h74, 0, 3'b000, 0);
    endtask

    task automatic test_simultaneous;
        send_frame(8'h29, 0, 3'b001, 0);
        send_frame(8'hE0, 0, 3'b001, 0);
        send_frame(8'h6B, 0, 3'b101, 0);
        send_frame(8'hF0, 0, 3'b101, 0);
        send_frame(8'h29, 0, 3'b100, 0);
    endtask

    task automatic test_bad_frames;
        // release left first
        send_frame(8'hE0, 0, 3'b100, 0);
        send_frame(8'hF0, 0, 3'b100, 0);
        send_frame(8'h6B, 0, 3'b000, 0);
        // extended code without E0 is ignored
        send_frame(8'h74, 0, 3'b000, 0);
        // bad parity after E0 drops the prefix, so the plain 6B is ignored
        send_frame(8'hE0, 0, 3'b000, 0);
        send_frame(8'h6B, 1, 3'b000, 1);
        send_frame(8'h6B, 0, 3'b000, 0);
        send_frame(8'hE0, 0, 3'b000, 0);
        send_frame(8'h6B, 0, 3'b100, 0);
    endtask

    task automatic test_timeout;
        int cnt;
        int first;
        cnt = 0;
        first = -1;
        // pending E0,F0 prefixes must be discarded by the timeout
        send_frame(8'hE0, 0, 3'b100, 0);
        send_frame(8'hF0, 0, 3'b100, 0);
        send_partial(8'h6B, 4);
        for (int n = HALF + 1; n <= TO + 40; n++) begin
            tick(1);
            if (frame_err === 1'b1) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
        checks++;
        if (cnt != 1) begin
            failures++;
            $display("FAIL timeout_count got=%0d exp=1", cnt);
        end
        checks++;
        if (first < TO + 1 || first > TO + 5) begin
            failures++;
            $display("FAIL timeout_time got=%0d exp=%0d..%0d", first, TO + 1, TO + 5);
        end
        checks++;
        if ({stepleft, stepright, stepjump} !== 3'b100) begin
            failures++;
            $display("FAIL timeout_keys got=%b exp=100", {stepleft, stepright, stepjump});
        end
        send_frame(8'h6B, 0, 3'b100, 0);
        send_frame(8'hE0, 0, 3'b100, 0);
        send_frame(8'hF0, 0, 3'b100, 0);
        send_frame(8'h6B, 0, 3'b000, 0);
    endtask

    task automatic test_reset_midframe;
        send_frame(8'hE0, 0, 3'b000, 0);
        send_frame(8'h74, 0, 3'b010, 0);
        send_partial(8'h29, 3);
        rst = 1'b1;
        #2;
        checks++;
        if ({stepleft, stepright, stepjump, frame_err} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset got=%b exp=0000", {stepleft, stepright, stepjump, frame_err});
        end
        tick(3);
        rst = 1'b0;
        tick(5);
        send_frame(8'hE0, 0, 3'b000, 0);
        send_frame(8'h74, 0, 3'b010, 0);
    endtask

    task automatic test_ext_jump;
        send_frame(8'hE0, 0, 3'b010, 0);
        send_frame(8'hF0, 0, 3'b010, 0);
        send_frame(8'h29, 0, 3'b010, 0);
        send_frame(8'h29, 0, 3'b011, 0);
        // typematic repeat keeps the level
        send_frame(8'h29, 0, 3'b011, 0);
    endtask

    initial begin
        test_reset;
        test_right_make_break;
        test_simultaneous;
        test_bad_frames;
        test_timeout;
        test_reset_midframe;
        test_ext_jump;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
